// File: rtl/pattern_detector_pkg.sv
// Shared sizing for the serial pattern detector: pattern length default,
// valid-bit counter width and match-count width.
package pattern_detector_pkg;

    localparam int PAT_W_DEF   = 4;
    localparam int MATCH_CNT_W = 8;

    // Counter must be able to hold the value PAT_W itself (saturation point).
    function automatic int cnt_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    localparam int CNT_W = cnt_width(PAT_W_DEF);

endpackage

// File: rtl/pd_shift_hist.sv
// Serial history shift register plus a valid-bit counter saturating at PAT_W.
// Both advance only on edges with input_valid=1 and otherwise hold.
module pd_shift_hist
    import pattern_detector_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CW    = cnt_width(PAT_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_in,
    input  logic          input_valid,
    output logic [PAT_W-1:0] history,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] CNT_MAX = CW'(PAT_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history <= '0;
            count   <= '0;
        end else if (input_valid) begin
            history <= {history[PAT_W-2:0], data_in};
            if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-stream pattern detector with overlapping detection.
// Optional saturating match counter when PATTERN_DETECTOR_MATCH_CNT_EN is defined.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             input_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             load_pattern,
    output logic             match
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
    ,
    output logic [MATCH_CNT_W-1:0] match_count
`endif
);

    localparam int CW = cnt_width(PAT_W);
    localparam logic [CW-1:0] CNT_PRE_FULL = CW'(PAT_W - 1);

    // data_in is a valid-only stream: a bit is consumed on every edge with
    // input_valid=1; there is no back-pressure, so no ready exists.
    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-1:0] history;
    logic [CW-1:0]    count;
    logic [PAT_W-1:0] candidate;
    logic             window_full;
    logic             hit;
    logic             unused_hist_msb;

    pd_shift_hist #(
        .PAT_W (PAT_W),
        .CW    (CW)
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .input_valid (input_valid),
        .history     (history),
        .count       (count)
    );

    // The oldest history bit is shifted out by the incoming bit.
    assign unused_hist_msb = history[PAT_W-1];

    always_comb begin
        candidate   = {history[PAT_W-2:0], data_in};
        window_full = (count >= CNT_PRE_FULL);
        hit         = input_valid && window_full && (candidate == pat_reg);
    end

    // pat_reg updates on the same edge that uses its old value for compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg <= '0;
            match   <= 1'b0;
        end else begin
            if (load_pattern) begin
                pat_reg <= pattern;
            end
            match <= hit;
        end
    end

`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_count <= '0;
        end else if (match && (match_count != {MATCH_CNT_W{1'b1}})) begin
            match_count <= match_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: hand-computed match sequences,
// reset behaviour, stalls, coincident load, and optional match counter.
module tb_pattern_detector;

    localparam int PAT_W = 4;

    logic             clk;
    logic             rst;
    logic             data_in;
    logic             input_valid;
    logic [PAT_W-1:0] pattern;
    logic             load_pattern;
    logic             match;
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
    logic [7:0]       match_count;
    int               exp_mc;
`endif

    int n_checks;
    int n_errors;

    pattern_detector #(.PAT_W(PAT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .input_valid  (input_valid),
        .pattern      (pattern),
        .load_pattern (load_pattern),
        .match        (match)
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
        ,
        .match_count  (match_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        input_valid  = 1'b0;
        load_pattern = 1'b0;
        data_in      = 1'b0;
        #1;
        check("reset_match", match, 0);
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
        exp_mc = 0;
        check("reset_mcnt", match_count, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load(input logic [PAT_W-1:0] p);
        @(negedge clk);
        pattern      = p;
        load_pattern = 1'b1;
        input_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("load_no_match", match, 0);
    endtask

    task automatic send_bit(input string tag, input logic b, input logic exp,
                            input logic do_load, input logic [PAT_W-1:0] p);
        @(negedge clk);
        data_in      = b;
        input_valid  = 1'b1;
        load_pattern = do_load;
        pattern      = p;
        @(posedge clk);
        #1;
        check(tag, match, exp);
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
        if (exp && exp_mc < 255) exp_mc++;
        // counter lags match by one edge; compare on the next idle/bit
`endif
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        input_valid  = 1'b0;
        load_pattern = 1'b0;
        @(posedge clk);
        #1;
        check(tag, match, 0);
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
        check({tag, "_mcnt"}, match_count, exp_mc);
`endif
    endtask

    // Drive a stream; bits and expected matches listed MSB-first (first sent = MSB).
    task automatic stream(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] exps);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(tag, bits[i], exps[i], 1'b0, '0);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        data_in      = 1'b0;
        input_valid  = 1'b0;
        pattern      = '0;
        load_pattern = 1'b0;
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
        exp_mc       = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("por_match", match, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1010 over 101010: matches at bits 4 and 6
        load(4'b1010);
        stream("s1010", 6, 16'b101010, 16'b000101);
        idle("s1010_idle");

        // 1000 over 1 0 0 0 1 0 0 0 0 1 1: matches at bits 4 and 8
        do_reset();
        load(4'b1000);
        stream("s1000", 11, 16'b10001000011, 16'b00010001000);
        idle("s1000_idle");

        // Pattern 0000 after reset still needs four fresh bits
        do_reset();
        stream("s0000", 4, 16'b0000, 16'b0001);
        idle("s0000_idle");

        // Partial history never matches
        do_reset();
        load(4'b1110);
        send_bit("partial", 1'b1, 1'b0, 1'b0, '0);
        idle("partial_idle");

        // Coincident load: bit checked against old 0001, new 1100 from next bit
        do_reset();
        load(4'b0001);
        stream("coin_pre", 3, 16'b000, 16'b000);
        send_bit("coin_old", 1'b1, 1'b1, 1'b1, 4'b1100);
        stream("coin_new", 3, 16'b100, 16'b001);
        idle("coin_idle");

        // 1001 overlap: matches at bits 8 and 11
        do_reset();
        load(4'b1001);
        stream("s1001", 11, 16'b00001001001, 16'b00000001001);
        idle("s1001_idle");

        // Gaps stall the stream, history and count are kept
        do_reset();
        load(4'b1010);
        stream("gap_a", 2, 16'b10, 16'b00);
        idle("gap_i0");
        idle("gap_i1");
        idle("gap_i2");
        stream("gap_b", 2, 16'b10, 16'b01);
        idle("gap_end");

        // Mid-stream reset while match is high: clears asynchronously
        stream("mid_pre", 2, 16'b10, 16'b01);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_match", match, 0);
`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
        exp_mc = 0;
        check("mid_rst_mcnt", match_count, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        load(4'b1010);
        stream("mid_post", 4, 16'b1010, 16'b0001);
        idle("mid_idle");

`ifdef PATTERN_DETECTOR_MATCH_CNT_EN
        // Saturation: pattern 0000 over a long zero run
        do_reset();
        send_bit("sat_pre", 1'b0, 1'b0, 1'b0, '0);
        send_bit("sat_pre", 1'b0, 1'b0, 1'b0, '0);
        send_bit("sat_pre", 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 260; i++) begin
            send_bit("sat_run", 1'b0, 1'b1, 1'b0, '0);
        end
        idle("sat_idle");
        check("sat_value", match_count, 255);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
